// File: rtl/ssb_replay_lock_ctrl.sv
// Per-load-port speculative-store-bypass guard: locks a port after a load issues past an
// unresolved older store, replaying loads until a countdown expires or (mode 1) that store resolves.
module ssb_replay_lock_ctrl #(
  parameter int LOAD_PORT_NUM         = 2,
  parameter int STORE_QUEUE_ENTRY_NUM = 16,
  parameter int LOCK_CNT_W            = 4,
  parameter int STAT_W                = 32,
  localparam int SQ_IDX_W             = $clog2(STORE_QUEUE_ENTRY_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfgEnable,
  input  logic                              cfgMode,
  input  logic [LOCK_CNT_W-1:0]             cfgLockCycles,
  input  logic                              flush,
  input  logic [LOAD_PORT_NUM-1:0]          ldValid,
  input  logic [LOAD_PORT_NUM-1:0]          ldUnresolvedOlder,
  input  logic [LOAD_PORT_NUM*SQ_IDX_W-1:0] ldWaitSqIdx,
  input  logic                              sqResolveValid,
  input  logic [SQ_IDX_W-1:0]               sqResolveIdx,
  output logic [LOAD_PORT_NUM-1:0]          ldReplay,
  output logic [LOAD_PORT_NUM-1:0]          lockActive,
  output logic [STAT_W-1:0]                 replayCount
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_r     [LOAD_PORT_NUM];
  state_t                  state_nxt_s [LOAD_PORT_NUM];
  logic [LOCK_CNT_W-1:0]   cnt_r       [LOAD_PORT_NUM];
  logic [LOCK_CNT_W-1:0]   cnt_nxt_s   [LOAD_PORT_NUM];
  logic [SQ_IDX_W-1:0]     widx_r      [LOAD_PORT_NUM];
  logic [SQ_IDX_W-1:0]     widx_nxt_s  [LOAD_PORT_NUM];
  logic [LOAD_PORT_NUM-1:0] trig_s;
  logic [STAT_W:0]          sum_s;
  logic [STAT_W-1:0]        replay_count_r;
  logic [STAT_W-1:0]        replay_count_nxt_s;

  function automatic logic [STAT_W:0] popcnt(input logic [LOAD_PORT_NUM-1:0] v);
    logic [STAT_W:0] acc;
    acc = '0;
    for (int i = 0; i < LOAD_PORT_NUM; i++) begin
      acc = acc + (STAT_W+1)'(v[i]);
    end
    return acc;
  endfunction

  // Trigger detection, replay decision and per-port next-state selection
  always_comb begin
    trig_s   = '0;
    ldReplay = '0;
    for (int p = 0; p < LOAD_PORT_NUM; p++) begin
      state_nxt_s[p] = state_r[p];
      cnt_nxt_s[p]   = cnt_r[p];
      widx_nxt_s[p]  = widx_r[p];
      trig_s[p] = cfgEnable & (cfgLockCycles != '0) & ldValid[p] & ldUnresolvedOlder[p] & ~flush;
      ldReplay[p] = ~rst & ~flush & ldValid[p] & ((state_r[p] == LOCKED) | trig_s[p]);
      if (flush) begin
        state_nxt_s[p] = IDLE;
        cnt_nxt_s[p]   = '0;
      end else if (trig_s[p]) begin
        cnt_nxt_s[p]  = cfgLockCycles;
        widx_nxt_s[p] = ldWaitSqIdx[p*SQ_IDX_W +: SQ_IDX_W];
        // A fresh lock is cancelled if its store resolves in the very same cycle
        if ((state_r[p] == IDLE) && cfgMode && sqResolveValid &&
            (sqResolveIdx == ldWaitSqIdx[p*SQ_IDX_W +: SQ_IDX_W])) begin
          state_nxt_s[p] = IDLE;
        end else begin
          state_nxt_s[p] = LOCKED;
        end
      end else begin
        case (state_r[p])
          LOCKED: begin
            cnt_nxt_s[p] = cnt_r[p] - LOCK_CNT_W'(1);
            if ((cfgMode && sqResolveValid && (sqResolveIdx == widx_r[p])) ||
                (cnt_r[p] == LOCK_CNT_W'(1))) begin
              state_nxt_s[p] = IDLE;
            end else begin
              state_nxt_s[p] = LOCKED;
            end
          end
          IDLE: begin
            state_nxt_s[p] = IDLE;
          end
          default: begin
            state_nxt_s[p] = IDLE;
          end
        endcase
      end
    end
  end

  // Saturating statistics accumulation
  always_comb begin
    sum_s = {1'b0, replay_count_r} + popcnt(ldReplay);
    if (sum_s[STAT_W]) begin
      replay_count_nxt_s = '1;
    end else begin
      replay_count_nxt_s = sum_s[STAT_W-1:0];
    end
  end

  // Per-port state, counter and waited-index registers
  always_ff @(posedge clk) begin
    for (int p = 0; p < LOAD_PORT_NUM; p++) begin
      if (rst) begin
        state_r[p] <= IDLE;
        cnt_r[p]   <= '0;
        widx_r[p]  <= '0;
      end else begin
        state_r[p] <= state_nxt_s[p];
        cnt_r[p]   <= cnt_nxt_s[p];
        widx_r[p]  <= widx_nxt_s[p];
      end
    end
  end

  // Replay statistics register
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_count_r <= '0;
    end else begin
      replay_count_r <= replay_count_nxt_s;
    end
  end

  // Lock status straight from the state registers
  always_comb begin
    lockActive = '0;
    for (int p = 0; p < LOAD_PORT_NUM; p++) begin
      lockActive[p] = (state_r[p] == LOCKED);
    end
  end

  assign replayCount = replay_count_r;

endmodule

// File: tb/tb_ssb_replay_lock_ctrl.sv
// Bench for ssb_replay_lock_ctrl: directed scenarios with literal expectations plus a randomized
// run, all checked each cycle against a remaining-lock-cycles model of each port.
module tb_ssb_replay_lock_ctrl;
  localparam int NP   = 2;
  localparam int IW   = 4;
  localparam int SW   = 8;
  localparam int SMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfgEnable;
  logic          cfgMode;
  logic [3:0]    cfgLockCycles;
  logic          flush;
  logic [NP-1:0] ldValid;
  logic [NP-1:0] ldUnresolvedOlder;
  logic [NP*IW-1:0] ldWaitSqIdx;
  logic          sqResolveValid;
  logic [IW-1:0] sqResolveIdx;
  logic [NP-1:0] ldReplay;
  logic [NP-1:0] lockActive;
  logic [SW-1:0] replayCount;

  int checks = 0;
  int errors = 0;

  // model: cycles each port stays locked from now on (0 = idle), awaited index, counter
  int rem [NP];
  int widx[NP];
  int mcount;

  ssb_replay_lock_ctrl #(
    .LOAD_PORT_NUM(NP), .STORE_QUEUE_ENTRY_NUM(16), .LOCK_CNT_W(4), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .cfgEnable(cfgEnable), .cfgMode(cfgMode),
    .cfgLockCycles(cfgLockCycles), .flush(flush), .ldValid(ldValid),
    .ldUnresolvedOlder(ldUnresolvedOlder), .ldWaitSqIdx(ldWaitSqIdx),
    .sqResolveValid(sqResolveValid), .sqResolveIdx(sqResolveIdx),
    .ldReplay(ldReplay), .lockActive(lockActive), .replayCount(replayCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      rem[p] = 0;
      widx[p] = 0;
    end
    mcount = 0;
  end

  // Model compare and advance on the falling edge, when inputs and outputs are stable
  always @(negedge clk) begin
    int exp_rep;
    int exp_lock;
    int wp;
    int pc;
    bit trig;
    bit hit;
    exp_rep  = 0;
    exp_lock = 0;
    pc = 0;
    for (int p = 0; p < NP; p++) begin
      wp   = int'(ldWaitSqIdx[p*IW +: IW]);
      trig = !rst && cfgEnable && (cfgLockCycles != 4'd0) && ldValid[p] &&
             ldUnresolvedOlder[p] && !flush;
      if (!rst && !flush && ldValid[p] && (rem[p] > 0 || trig)) begin
        exp_rep = exp_rep | (1 << p);
        pc++;
      end
      if (rem[p] > 0) exp_lock = exp_lock | (1 << p);
    end
    chk("cmp_ldReplay", int'(ldReplay), exp_rep);
    chk("cmp_lockActive", int'(lockActive), exp_lock);
    chk("cmp_replayCount", int'(replayCount), mcount);
    if (rst) begin
      mcount = 0;
      for (int p = 0; p < NP; p++) begin
        rem[p] = 0;
        widx[p] = 0;
      end
    end else begin
      mcount = (mcount + pc > SMAX) ? SMAX : mcount + pc;
      for (int p = 0; p < NP; p++) begin
        wp   = int'(ldWaitSqIdx[p*IW +: IW]);
        trig = cfgEnable && (cfgLockCycles != 4'd0) && ldValid[p] && ldUnresolvedOlder[p];
        if (flush) begin
          rem[p] = 0;
        end else if (trig) begin
          hit = cfgMode && sqResolveValid && (int'(sqResolveIdx) == wp);
          widx[p] = wp;
          rem[p] = (rem[p] == 0 && hit) ? 0 : int'(cfgLockCycles);
        end else if (rem[p] > 0) begin
          hit = cfgMode && sqResolveValid && (int'(sqResolveIdx) == widx[p]);
          rem[p] = hit ? 0 : rem[p] - 1;
        end
      end
    end
  end

  task automatic idle_inputs();
    ldValid = '0;
    ldUnresolvedOlder = '0;
    sqResolveValid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic trig_p0(input logic [3:0] idx);
    ldValid = 2'b01;
    ldUnresolvedOlder = 2'b01;
    ldWaitSqIdx = {4'd0, idx};
  endtask

  initial begin
    rst = 1'b1; cfgEnable = 1'b1; cfgMode = 1'b0; cfgLockCycles = 4'd4;
    flush = 1'b0; ldValid = 2'b11; ldUnresolvedOlder = 2'b11; ldWaitSqIdx = '0;
    sqResolveValid = 1'b0; sqResolveIdx = '0;
    cyc();
    chk("rst_ldReplay", int'(ldReplay), 0);
    chk("rst_lockActive", int'(lockActive), 0);
    chk("rst_replayCount", int'(replayCount), 0);
    cyc();
    rst = 1'b0; idle_inputs();
    cyc();

    // mode 0, L=4
    trig_p0(4'd7); #1 chk("m0_trig_replay", int'(ldReplay), 1);
    cyc(); idle_inputs(); #1 chk("m0_lock_t1", int'(lockActive), 1);
    cyc(); #1 chk("m0_lock_t2", int'(lockActive), 1);
    cyc(); ldValid = 2'b01; #1 chk("m0_locked_replay", int'(ldReplay), 1);
    cyc(); idle_inputs(); #1 chk("m0_lock_t4", int'(lockActive), 1);
    cyc(); #1 chk("m0_lock_t5", int'(lockActive), 0);
    chk("m0_count", int'(replayCount), 2);

    // mode 1, L=15, early release on matching resolve only
    cfgMode = 1'b1; cfgLockCycles = 4'd15;
    trig_p0(4'd5);
    cyc(); idle_inputs();
    cyc(); sqResolveValid = 1'b1; sqResolveIdx = 4'd3;
    cyc(); sqResolveValid = 1'b0;
    cyc(); sqResolveValid = 1'b1; sqResolveIdx = 4'd5; #1 chk("m1_lock_t4", int'(lockActive), 1);
    cyc(); sqResolveValid = 1'b0; #1 chk("m1_lock_t5", int'(lockActive), 0);

    // mode 1 timeout
    trig_p0(4'd5);
    for (int k = 1; k <= 15; k++) begin
      cyc(); idle_inputs();
    end
    #1 chk("m1_timeout_t15", int'(lockActive), 1);
    cyc(); #1 chk("m1_timeout_t16", int'(lockActive), 0);

    // mode 0 retrigger with shorter length
    cfgMode = 1'b0; cfgLockCycles = 4'd4;
    trig_p0(4'd2);
    cyc(); idle_inputs();
    cyc(); cfgLockCycles = 4'd2; trig_p0(4'd3);
    cyc(); idle_inputs();
    cyc(); #1 chk("retrig_lock_t4", int'(lockActive), 1);
    cyc(); #1 chk("retrig_lock_t5", int'(lockActive), 0);

    // flush during a lock
    cfgLockCycles = 4'd4;
    trig_p0(4'd1);
    cyc(); flush = 1'b1; trig_p0(4'd1); #1 chk("flush_replay", int'(ldReplay), 0);
    cyc(); idle_inputs(); #1 chk("flush_lock", int'(lockActive), 0);

    // disabled guard and zero length
    cfgEnable = 1'b0; ldValid = 2'b11; ldUnresolvedOlder = 2'b11;
    #1 chk("dis_replay", int'(ldReplay), 0);
    cyc(); cfgEnable = 1'b1; cfgLockCycles = 4'd0; #1 chk("dis_lock", int'(lockActive), 0);
    chk("l0_replay", int'(ldReplay), 0);
    cyc(); idle_inputs(); #1 chk("l0_lock", int'(lockActive), 0);
    chk("dis_count", int'(replayCount), 7);

    // both ports, shared resolve in mode 1
    cfgMode = 1'b1; cfgLockCycles = 4'd15;
    ldValid = 2'b11; ldUnresolvedOlder = 2'b11; ldWaitSqIdx = {4'd9, 4'd9};
    #1 chk("both_replay", int'(ldReplay), 3);
    cyc(); idle_inputs(); sqResolveValid = 1'b1; sqResolveIdx = 4'd9;
    #1 chk("both_lock", int'(lockActive), 3);
    cyc(); sqResolveValid = 1'b0; #1 chk("both_release", int'(lockActive), 0);
    chk("both_count", int'(replayCount), 9);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i % 50 == 0) begin
        cfgMode = 1'($urandom);
        cfgLockCycles = 4'($urandom_range(0, 15));
        cfgEnable = ($urandom % 8) != 0;
      end
      ldValid = 2'($urandom);
      ldUnresolvedOlder = 2'($urandom);
      ldWaitSqIdx = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      sqResolveValid = ($urandom % 3) == 0;
      sqResolveIdx = 4'($urandom_range(0, 3));
      flush = ($urandom % 40) == 0;
    end
    cyc(); idle_inputs(); #1 chk("sat_count", int'(replayCount), SMAX);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1 chk("final_rst_count", int'(replayCount), 0);
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
